// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//
// Downstream stage of the bridge's byte FIFO. It pulls one byte from the
// FIFO read port and sends it on the UART TX line as 8N1: one start bit,
// 8 data bits LSB first, then one stop bit. It only issues a read when the
// FIFO reports a byte available and transmit is enabled.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   i_data        FIFO output byte
//   i_fifo_empty  FIFO empty flag (high = nothing to read)
//   i_tx_enable   flow-control gate, sampled only while idle
//   en_read       registered FIFO read strobe, one cycle per byte
//   o_tx          UART serial line, idle high
//   o_busy        high whenever a byte is being fetched or sent
//   o_done        one-cycle pulse after each stop bit completes

module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_data,
  input  logic       i_fifo_empty,
  input  logic       i_tx_enable,
  output logic       en_read,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             en_read_d;
  logic             done_d;
  logic             bit_end;

  // The baud counter reaching its terminal value marks the last cycle of
  // the current bit on the line.
  assign bit_end = (cnt_q == CNT_LAST);

  assign o_busy = (state_q != S_IDLE);

  // All outputs except o_busy are registered, so a reset forces the line
  // high and the read strobe low without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      o_tx      <= 1'b1;
      en_read   <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      o_tx      <= tx_d;
      en_read   <= en_read_d;
      o_done    <= done_d;
    end
  end

  // Next-state logic. The read strobe and the done pulse default low so
  // each lasts exactly one cycle. The byte is captured in LATCH, one cycle
  // after the strobe, because the FIFO's registered output only reflects
  // the popped byte after the edge that ends the strobe. The line value for
  // the next bit is computed one edge ahead so o_tx changes exactly on bit
  // boundaries.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = o_tx;
    en_read_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_enable && !i_fifo_empty) begin
          en_read_d = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        shift_d = i_data;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Downstream stage of the byte FIFO in the I2C-to-UART bridge. It pulls one byte at a time from the FIFO read port and serializes it onto the UART TX line as 8N1: one start bit, 8 data bits LSB first, one stop bit. It owns the FIFO `en_read` strobe and never reads while the FIFO reports empty.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868 — clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports:
- `clk` — input, 1 — system clock; all state updates on the rising edge.
- `reset_n` — input, 1 — asynchronous, active-low reset.
- `i_data` — input, 8 — FIFO `o_data`.
- `i_fifo_empty` — input, 1 — FIFO underflow/empty flag; high = no byte available.
- `i_tx_enable` — input, 1 — flow-control gate; sampled only in IDLE.
- `en_read` — output, 1 — FIFO read strobe; registered, high for exactly 1 cycle per byte.
- `o_tx` — output, 1 — UART serial line; idle high.
- `o_busy` — output, 1 — high in every state except IDLE.
- `o_done` — output, 1 — 1-cycle pulse when a stop bit completes.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: `o_tx`=1. If `i_tx_enable` && !`i_fifo_empty` at the edge, set `en_read`<=1 and go to FETCH. Otherwise stay.
- FETCH: `en_read` is high for this one cycle. At the next edge the FIFO updates `o_data`. Set `en_read`<=0 and go to LATCH.
- LATCH: at the next edge:
  - `shift`<=`i_data`
  - `o_tx`<=0
  - baud counter<=0
  - go to START
- START: hold `o_tx`=0 for `CLKS_PER_BIT` cycles. Then `o_tx`<=`shift[0]`, bit index<=0, go to DATA.
- DATA: each bit is held `CLKS_PER_BIT` cycles. At the end of each bit, shift right and drive the next bit. After bit index 7 completes, `o_tx`<=1 and go to STOP.
- STOP: hold `o_tx`=1 for `CLKS_PER_BIT` cycles. At the final edge, pulse `o_done`<=1 for one cycle and go to IDLE.
- Widths:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT`-1 and clears on bit boundaries; no wrap beyond terminal.
  - Bit index is 3 bits.
- `i_tx_enable` deasserted mid-frame has no effect; the current frame completes.
- `i_fifo_empty` is ignored outside IDLE.
- `i_data` is sampled only in LATCH, so later FIFO changes do not corrupt the frame.
- Reset values (asynchronous on `reset_n`=0):
  - state=IDLE, `o_tx`=1, `en_read`=0, `o_busy`=0, `o_done`=0, shift=0, counters=0.
  - Reset mid-frame aborts the frame immediately: line goes high, no `o_done`, and no byte is re-read.
- After `reset_n` rises, the first possible `en_read` occurs at the first clock edge.

## Timing
- Edge k: IDLE sees the request. Edge k+1: `en_read` drops (high during cycle k..k+1). Edge k+2: start bit begins.
- Frame duration: 10×`CLKS_PER_BIT` cycles from the start-bit edge to the STOP→IDLE edge.
- `o_done` is high during the cycle immediately after the STOP→IDLE edge.
- Back-to-back frames with a non-empty FIFO: exactly 3 idle-high cycles between one stop bit's end and the next start bit.
- Maximum read rate is one `en_read` per 10×`CLKS_PER_BIT`+3 cycles. This guarantees the FIFO's registered empty flag has settled before the next IDLE sample.
- `en_read` is never asserted on two consecutive cycles.

## Test plan
- Single byte: `CLKS_PER_BIT`=4, FIFO holds 0xA5.
  - `en_read` pulses once.
  - `o_tx` after the 2-cycle latency: 0 ×4, then 1,0,1,0,0,1,0,1 ×4 each, then 1 ×4.
  - `o_done` pulses at cycle 42; `o_busy` is high for 42 cycles.
- Back-to-back: FIFO holds 0x00 then 0xFF.
  - Two frames, with exactly 3 high cycles between the first stop end and the second start.
  - Exactly two `en_read` pulses.
- Empty FIFO: `i_fifo_empty`=1 for 100 cycles. Expect `en_read`=0, `o_tx`=1, `o_busy`=0 throughout.
- Flow control: `i_tx_enable`=0 with a non-empty FIFO → no read. Raise it → frame starts 2 cycles later. Drop it during DATA → frame completes and no further read occurs.
- Reset mid-frame: assert `reset_n`=0 during bit 3 of 0x3C.
  - `o_tx`=1 and `en_read`=0 asynchronously, and no `o_done`.
  - After release with the FIFO non-empty, the next frame starts cleanly 2 cycles after the first edge.
- Data-change immunity: change `i_data` to 0xFF during DATA of a 0x5A frame. Transmitted bits still encode 0x5A.
